// File: rtl/sail_mem_pkg.sv
// Shared types for the emulator memory sequencers: FSM states, the byte-write
// record and the captured request record.
package sail_mem_pkg;

  localparam int SAIL_MEM_ADDR_W = 64;
  // Data capacity of the request record; sequencers use the low MAX_BYTES bytes.
  localparam int SAIL_REQ_BYTES_CAP = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    TAG   = 2'd2,
    RESP  = 2'd3
  } sail_mseq_state;

  typedef struct packed {
    logic [SAIL_MEM_ADDR_W-1:0] paddr;
    logic [7:0]                 data;
  } sail_write_t;

  typedef struct packed {
    logic [SAIL_MEM_ADDR_W-1:0]      addr;
    logic [7:0]                      nbytes;
    logic [SAIL_REQ_BYTES_CAP*8-1:0] data;
    logic                            tag_en;
    logic                            tag_value;
  } sail_mem_req_t;

endpackage

// File: rtl/sail_mem_write_sequencer_if.sv
// Requester and memory-side bundle of the write sequencer.
// req_valid/req_ready: requester r transfers on a rising edge where req_valid[r] and
// req_ready[r] are both high; mem_we/tag_we transfer on a rising edge with mem_ready high.
interface sail_mem_write_sequencer_if #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BYTES = 8,
  parameter int CNT_W     = $clog2(MAX_BYTES + 1)
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ*64-1:0]          req_addr;
  logic [NUM_REQ*CNT_W-1:0]       req_nbytes;
  logic [NUM_REQ*MAX_BYTES*8-1:0] req_data;
  logic [NUM_REQ-1:0]             req_tag_en;
  logic [NUM_REQ-1:0]             req_tag_value;
  logic [NUM_REQ-1:0]             done;
  logic                           busy;
  logic                           mem_we;
  logic                           tag_we;
  logic [63:0]                    mem_addr;
  logic [7:0]                     mem_wdata;
  logic                           tag_wdata;
  logic                           mem_ready;
  logic [1:0]                     dbg_state;

  modport master (
    output req_valid, req_addr, req_nbytes, req_data, req_tag_en, req_tag_value, mem_ready,
    input  req_ready, done, busy, mem_we, tag_we, mem_addr, mem_wdata, tag_wdata, dbg_state
  );

  modport slave (
    input  req_valid, req_addr, req_nbytes, req_data, req_tag_en, req_tag_value, mem_ready,
    output req_ready, done, busy, mem_we, tag_we, mem_addr, mem_wdata, tag_wdata, dbg_state
  );
endinterface

// File: rtl/sail_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant+1 (mod N) and
// returns a one-hot grant for the first asserted request, or zero.
module sail_rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_grant_i,
  output logic [N-1:0]  grant_o
);

  int cand;

  always_comb begin
    grant_o = '0;
    cand    = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last_grant_i) + k) % N;
      if (grant_o == '0 && req_i[cand]) grant_o[cand] = 1'b1;
    end
  end

endmodule

// File: rtl/sail_mem_write_sequencer.sv
// Round-robin shared writer for the emulator byte memory and tag store: each
// accepted request becomes little-endian byte writes, an optional tag write, then done.
module sail_mem_write_sequencer #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BYTES = 8,
  parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input logic                      clk,
  input logic                      rst_n,
  sail_mem_write_sequencer_if.slave bus
);
  import sail_mem_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sail_mseq_state   state_q, state_d;
  logic [IDX_W-1:0] last_grant_q, owner_q, win_idx;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] sel_nb, sel_n;
  sail_mem_req_t    req_q, sel_req;
  logic [NUM_REQ-1:0] grant, ready, done;
  logic             accept;
  sail_write_t      wr;
  logic             mem_we, tag_we, tag_wdata;

  sail_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i        (bus.req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_idx = IDX_W'(i);
    end
  end

  // Winner's fields, with the byte count clamped to MAX_BYTES.
  always_comb begin
    sel_nb            = bus.req_nbytes[win_idx*CNT_W +: CNT_W];
    sel_n             = (sel_nb > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : sel_nb;
    sel_req           = '0;
    sel_req.addr      = bus.req_addr[win_idx*SAIL_MEM_ADDR_W +: SAIL_MEM_ADDR_W];
    sel_req.nbytes    = 8'(sel_n);
    sel_req.data[MAX_BYTES*8-1:0] = bus.req_data[win_idx*MAX_BYTES*8 +: MAX_BYTES*8];
    sel_req.tag_en    = bus.req_tag_en[win_idx];
    sel_req.tag_value = bus.req_tag_value[win_idx];
  end

  // Ready is masked during reset so no requester sees a grant before state is defined.
  assign ready  = (state_q == IDLE && rst_n) ? grant : '0;
  assign accept = |ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done      = '0;
    wr        = '0;
    mem_we    = 1'b0;
    tag_we    = 1'b0;
    tag_wdata = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d = '0;
          if (sel_n != '0)        state_d = WRITE;
          else if (sel_req.tag_en) state_d = TAG;
          else                     state_d = RESP;
        end
      end
      WRITE: begin
        mem_we   = 1'b1;
        wr.paddr = req_q.addr + SAIL_MEM_ADDR_W'(idx_q);
        wr.data  = req_q.data[idx_q*8 +: 8];
        if (bus.mem_ready) begin
          if (8'(idx_q) == req_q.nbytes - 8'd1) state_d = req_q.tag_en ? TAG : RESP;
          else                                  idx_d   = idx_q + CNT_W'(1);
        end
      end
      TAG: begin
        tag_we    = 1'b1;
        wr.paddr  = req_q.addr;
        tag_wdata = req_q.tag_value;
        if (bus.mem_ready) state_d = RESP;
      end
      RESP: begin
        done[owner_q] = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      owner_q      <= '0;
      idx_q        <= '0;
      req_q        <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) begin
        req_q        <= sel_req;
        owner_q      <= win_idx;
        last_grant_q <= win_idx;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.done      = done;
  assign bus.busy      = (state_q != IDLE);
  assign bus.mem_we    = mem_we;
  assign bus.tag_we    = tag_we;
  assign bus.mem_addr  = wr.paddr;
  assign bus.mem_wdata = wr.data;
  assign bus.tag_wdata = tag_wdata;
  assign bus.dbg_state = state_q;

endmodule

// File: doc/sail_mem_write_sequencer.md
Name: sail_mem_write_sequencer

Overview:
- Shares the emulator byte-wide memory and tag store between NUM_REQ requesters.
- Each requester submits one write of up to MAX_BYTES bytes, with an optional tag write.
- The block arbitrates round-robin and serialises each accepted write into little-endian byte writes (byte i goes to addr+i), followed by an optional tag write.
- It completes the transaction with a per-requester done pulse. It is the clocked counterpart of the emulator write-mem/write-tag functions.

Parameters:
- NUM_REQ, 2, number of requesters (1..8)
- MAX_BYTES, 8, maximum bytes per write request
- CNT_W, $clog2(MAX_BYTES+1), width of byte-count fields

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  request present, one bit per requester
- req_ready  out  NUM_REQ  request accepted; one-hot or zero
- req_addr  in  NUM_REQ*64  base physical address per requester
- req_nbytes  in  NUM_REQ*CNT_W  byte count per requester
- req_data  in  NUM_REQ*MAX_BYTES*8  write data; byte i in bits [8i+7:8i]
- req_tag_en  in  NUM_REQ  also write the tag at the base address
- req_tag_value  in  NUM_REQ  tag value to write
- done  out  NUM_REQ  one-cycle completion pulse for the owning requester
- busy  out  1  state != IDLE
- mem_we  out  1  byte write strobe
- tag_we  out  1  tag write strobe
- mem_addr  out  64  byte or tag address
- mem_wdata  out  8  byte write data
- tag_wdata  out  1  tag write data
- mem_ready  in  1  memory accepts the current mem_we/tag_we this cycle

Behaviour:
- States: IDLE, WRITE, TAG, RESP (enum, 2 bits).
- Reset (async assert, sync-safe deassert):
  - state=IDLE, last_grant=NUM_REQ-1, so requester 0 has first priority.
  - Outputs while in reset: req_ready=0, done=0, busy=0, mem_we=0, tag_we=0, mem_addr=0, mem_wdata=0, tag_wdata=0.
- Reset mid-operation: the transaction is abandoned. Bytes already accepted by memory stay written; no done is issued.
- IDLE:
  - Winner = first requester with req_valid set, searching from last_grant+1 modulo NUM_REQ.
  - req_ready[winner]=1 combinationally. All other req_ready bits are 0. req_ready is 0 in every state other than IDLE.
  - On handshake, capture addr, data, tag_en, tag_value and owner; set last_grant=winner.
  - Captured n = min(req_nbytes, MAX_BYTES).
  - Next state: WRITE if n>0; else TAG if tag_en; else RESP.
- WRITE:
  - mem_we=1, mem_addr=base+idx (64-bit modulo, wraps 0xFFFF_FFFF_FFFF_FFFF -> 0), mem_wdata=data byte idx.
  - idx starts at 0 and advances only when mem_ready=1.
  - After byte n-1 is accepted: TAG if tag_en, else RESP.
- TAG:
  - tag_we=1, mem_addr=base, tag_wdata=tag_value.
  - Leave to RESP when mem_ready=1.
- RESP: done[owner]=1 for exactly one cycle, then IDLE.
- Output stability: mem_we and tag_we are never high together. While mem_ready=0, all mem_*/tag_* outputs hold stable.
- mem_addr and mem_wdata are 0 when neither strobe is high.
- Requester inputs are sampled only at the handshake; later changes have no effect.
- Latency with mem_ready held at 1, counting the accept edge as cycle 0:
  - Byte k is written in cycle k+1.
  - done appears in cycle n+1, or n+2 with a tag write.
  - Next accept in cycle n+2, or n+3 with a tag write.
- A requester that drops req_valid before being granted is simply skipped. Fairness: a continuously valid requester is granted within NUM_REQ grants.

Decomposition:
- Shared package sail_mem_pkg holds:
  - the state enum (sail_mseq_state)
  - the byte-write struct (paddr[63:0], data[7:0]), matching the existing sail_write layout
  - a request struct (addr, nbytes, data, tag_en, tag_value)
  - the SAIL_MEM_ADDR_W=64 constant
- One sub-module, sail_rr_arbiter (parameter N):
  - inputs: req vector, last_grant
  - output: one-hot grant
  - purely combinational, reused by future read/ifetch sequencers.

Test Plan:
- Single write, mem_ready=1: req0 addr=0x1000, nbytes=4, data=0xDDCCBBAA, tag_en=0.
  - Required: bytes AA,BB,CC,DD at 0x1000..0x1003 in cycles 1..4; done[0] in cycle 5; busy low in cycle 6.
- Backpressure: same request with mem_ready low on alternate cycles.
  - Required: each byte's address/data held until accepted; no byte skipped or duplicated; done[0] only after byte 3 accepted.
- Contention: req0 and req1 both valid continuously, nbytes=1 each.
  - Required: grants alternate 0,1,0,1 starting with 0; req_ready never has two bits set.
- Tag and zero-length requests:
  - req1 addr=0x2000, nbytes=2, tag_en=1, tag_value=1 -> two byte writes, then tag_we with mem_addr=0x2000 and tag_wdata=1, then done[1].
  - nbytes=0, tag_en=0 -> done pulse in the cycle after accept, with no memory strobes.
- Wrap and clamp: addr=0xFFFF_FFFF_FFFF_FFFE, nbytes=15.
  - Required: clamped to 8 bytes at ...FE, ...FF, 0x0 .. 0x5.
- Reset mid-write: assert rst_n=0 after byte 1 of 4.
  - Required: all outputs 0 immediately (asynchronously); no done issued; after release, req0 wins first.
